// File: rtl/ss_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ss_seq_if
// Brief    : Request, mapper save-state port and byte streams of ss_seq.
// Revision : 1.0
// ============================================================================
interface ss_seq_if;
    logic       start_save;
    logic       start_load;
    logic       busy;
    logic       done;
    logic       err;
    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic [7:0] out_dat;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_dat;
    logic       in_valid;
    logic       in_ready;

    modport master (
        input  start_save, start_load, ss_rdat, out_ready, in_dat, in_valid,
        output busy, done, err, ss_act, ss_we, ss_addr, ss_wdat,
               out_dat, out_valid, in_ready
    );

    modport slave (
        output start_save, start_load, ss_rdat, out_ready, in_dat, in_valid,
        input  busy, done, err, ss_act, ss_we, ss_addr, ss_wdat,
               out_dat, out_valid, in_ready
    );
endinterface
`default_nettype wire

// File: rtl/ss_seq.sv
`default_nettype none
// ============================================================================
// Module   : ss_seq
// Brief    : Save-state sequencer: dumps mapper registers to a byte stream and
//            restores them from one, writing on M2 falling edges.
// Revision : 1.0
// ============================================================================
module ss_seq #(
    parameter int SS_LEN = 128,
    parameter int SETTLE = 2,
    parameter int M2_TMO = 4096
) (
    input  wire        clk,
    input  wire        map_rst,
    input  wire        m2,
    ss_seq_if.master   bus
);

    localparam int c_cnt_max = (SETTLE > M2_TMO) ? SETTLE : M2_TMO;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE);
    localparam logic [c_cnt_w-1:0] c_tmo_last    = c_cnt_w'(M2_TMO - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_sat     = c_cnt_w'(c_cnt_max);
    localparam logic [7:0]         c_addr_last   = 8'(SS_LEN - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rd_set  = 3'd1;
    localparam logic [2:0] c_st_rd_push = 3'd2;
    localparam logic [2:0] c_st_wr_get  = 3'd3;
    localparam logic [2:0] c_st_wr_rise = 3'd4;
    localparam logic [2:0] c_st_wr_fall = 3'd5;
    localparam logic [2:0] c_st_fin     = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_nxt_state;

    logic [1:0]         r_m2_sync;
    logic               r_m2_prev;
    logic               w_m2_rise;
    logic               w_m2_fall;

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_settled;
    logic               w_tmo_hit;
    logic               w_addr_last;
    logic               w_abort;

    logic [7:0]         r_addr;
    logic [7:0]         r_wdat;
    logic [7:0]         r_out_dat;
    logic               r_err;

    logic               r_active;
    logic               r_done;
    logic               r_we;
    logic               r_out_valid;
    logic               r_in_ready;

    logic               w_active;
    logic               w_done;
    logic               w_we;
    logic               w_out_valid;
    logic               w_in_ready;

    // M2 is asynchronous: two-flop synchronizer, then edge detect.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            r_m2_sync <= 2'b00;
            r_m2_prev <= 1'b0;
        end else begin
            r_m2_sync <= {r_m2_sync[0], m2};
            r_m2_prev <= r_m2_sync[1];
        end
    end

    assign w_m2_rise   = r_m2_sync[1] & ~r_m2_prev;
    assign w_m2_fall   = ~r_m2_sync[1] & r_m2_prev;

    assign w_settled   = (r_cnt == c_settle_last);
    assign w_tmo_hit   = (r_cnt == c_tmo_last);
    assign w_addr_last = (r_addr == c_addr_last);
    assign w_abort     = ((r_state == c_st_wr_rise) && !w_m2_rise && w_tmo_hit) ||
                         ((r_state == c_st_wr_fall) && !w_m2_fall && w_tmo_hit);

    always_ff @(posedge clk) begin
        if (map_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.start_save) begin
                    w_nxt_state = c_st_rd_set;
                end else if (bus.start_load) begin
                    w_nxt_state = c_st_wr_get;
                end
            end
            c_st_rd_set: begin
                if (w_settled) begin
                    w_nxt_state = c_st_rd_push;
                end
            end
            c_st_rd_push: begin
                if (bus.out_ready) begin
                    w_nxt_state = w_addr_last ? c_st_fin : c_st_rd_set;
                end
            end
            c_st_wr_get: begin
                if (bus.in_valid) begin
                    w_nxt_state = c_st_wr_rise;
                end
            end
            c_st_wr_rise: begin
                if (w_m2_rise) begin
                    w_nxt_state = c_st_wr_fall;
                end else if (w_tmo_hit) begin
                    w_nxt_state = c_st_fin;
                end
            end
            c_st_wr_fall: begin
                if (w_m2_fall) begin
                    w_nxt_state = w_addr_last ? c_st_fin : c_st_wr_get;
                end else if (w_tmo_hit) begin
                    w_nxt_state = c_st_fin;
                end
            end
            c_st_fin: begin
                w_nxt_state = c_st_idle;
            end
            default: begin
                w_nxt_state = c_st_idle;
            end
        endcase
        if (map_rst) begin
            w_nxt_state = c_st_idle;
        end
    end

    // Outputs decode the next state and are registered, so they are glitch
    // free and line up exactly with the state they belong to.
    always_comb begin
        w_active    = 1'b0;
        w_done      = 1'b0;
        w_we        = 1'b0;
        w_out_valid = 1'b0;
        w_in_ready  = 1'b0;
        case (w_nxt_state)
            c_st_rd_set:  w_active = 1'b1;
            c_st_rd_push: begin
                w_active    = 1'b1;
                w_out_valid = 1'b1;
            end
            c_st_wr_get: begin
                w_active   = 1'b1;
                w_in_ready = 1'b1;
            end
            c_st_wr_rise, c_st_wr_fall: begin
                w_active = 1'b1;
                w_we     = 1'b1;
            end
            c_st_fin:     w_done = 1'b1;
            default:      w_active = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            r_active    <= 1'b0;
            r_done      <= 1'b0;
            r_we        <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_active    <= w_active;
            r_done      <= w_done;
            r_we        <= w_we;
            r_out_valid <= w_out_valid;
            r_in_ready  <= w_in_ready;
        end
    end

    // One counter serves both the settle wait and the per-edge M2 timeout;
    // it restarts on every state change and saturates so it cannot wrap.
    always_ff @(posedge clk) begin
        if (map_rst || (w_nxt_state != r_state)) begin
            r_cnt <= '0;
        end else if (r_cnt != c_cnt_sat) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            r_addr    <= 8'h00;
            r_wdat    <= 8'h00;
            r_out_dat <= 8'h00;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start_save || bus.start_load) begin
                        r_addr <= 8'h00;
                        r_err  <= 1'b0;
                    end
                end
                c_st_rd_set: begin
                    if (w_settled) begin
                        r_out_dat <= bus.ss_rdat;
                    end
                end
                c_st_rd_push: begin
                    if (bus.out_ready && !w_addr_last) begin
                        r_addr <= r_addr + 8'd1;
                    end
                end
                c_st_wr_get: begin
                    if (bus.in_valid) begin
                        r_wdat <= bus.in_dat;
                    end
                end
                c_st_wr_fall: begin
                    // Address moves on the same edge that drops ss_we.
                    if (w_m2_fall && !w_addr_last) begin
                        r_addr <= r_addr + 8'd1;
                    end
                end
                default: begin
                    r_addr <= r_addr;
                end
            endcase
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.busy      = r_active;
    assign bus.ss_act    = r_active;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.ss_we     = r_we;
    assign bus.ss_addr   = r_addr;
    assign bus.ss_wdat   = r_wdat;
    assign bus.out_dat   = r_out_dat;
    assign bus.out_valid = r_out_valid;
    assign bus.in_ready  = r_in_ready;

endmodule
`default_nettype wire

// File: doc/ss_seq.md
# ss_seq

Save-state sequencer that drives a mapper's save-state control port (ss_act, ss_we, ss_addr, write data) and reads back ss_rdat. Sits directly upstream of every mapper's ss_ctrl input: on a save request it walks the mapper's register space and streams each byte out; on a load request it accepts a byte stream and writes each byte back into the mapper's registers on M2 falling edges, where the mapper latches them. Runs in the fast system clock domain; M2 is sampled asynchronously.

## Interface
Parameters:
- SS_LEN, 128: number of save-state bytes; addresses 0..SS_LEN-1 (max 256).
- SETTLE, 2: clk cycles between an ss_addr change and sampling ss_rdat.
- M2_TMO, 4096: clk cycles to wait for an M2 edge before aborting a load.

Ports:
- clk  in  1  system clock.
- map_rst  in  1  synchronous, active-high reset.
- m2  in  1  CPU M2, asynchronous to clk.
- start_save  in  1  one-cycle request: dump registers.
- start_load  in  1  one-cycle request: restore registers.
- busy  out  1  high while a sequence runs.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  sticky load-abort flag; cleared by the next start or by reset.
- ss_act  out  1  save-state access active; the mapper ignores the CPU bus while it is high.
- ss_we  out  1  save-state write enable.
- ss_addr  out  8  register index.
- ss_wdat  out  8  write data; the top level muxes it onto cpu_dat while ss_act is high.
- ss_rdat  in  8  mapper readback.
- out_dat  out  8, out_valid  out  1, out_ready  in  1: save stream.
- in_dat  in  8, in_valid  in  1, in_ready  out  1: load stream.

## Operation
- M2 path: 2-flop synchronizer, then rise and fall detect on the synchronized value.
- States:
  - IDLE
  - RD_SET: wait SETTLE cycles.
  - RD_PUSH: out_valid high until out_ready.
  - WR_GET: in_ready high until in_valid.
  - WR_RISE: wait for an M2 rise.
  - WR_FALL: wait for an M2 fall.
  - FIN
- Transitions from IDLE:
  - start_save → RD_SET, with addr=0 and ss_act=1.
  - start_load → WR_GET, with addr=0 and ss_act=1.
  - Both asserted in the same cycle: save wins.
  - A start while busy is ignored.
- Save loop, RD_SET → RD_PUSH:
  - out_dat is captured from ss_rdat on the last settle cycle and held stable while out_valid is high.
  - On the transfer: if addr==SS_LEN-1 go to FIN; otherwise addr+1 and return to RD_SET.
- Load loop:
  - WR_GET: on in_valid&in_ready, latch ss_wdat=in_dat and go to WR_RISE.
  - WR_RISE and WR_FALL: ss_we=1.
  - On the M2 fall: ss_we=0. If it was the last byte go to FIN; otherwise addr+1 and go to WR_GET.
  - Waiting for a rise before the fall guarantees at least a half M2 period of address/data setup before the latching edge.
- Timeout: in WR_RISE or WR_FALL, a counter runs. Reaching M2_TMO sets err, drops ss_we, and goes to FIN.
- FIN: ss_act=0, done=1 for one cycle, then IDLE.
- The address counter is 8 bits and never wraps past SS_LEN-1. SS_LEN=256 ends at 255 without overflow into 0.
- map_rst at any time: next state is IDLE and every output returns to its reset value. No done pulse is generated.

## Timing
- Reset values: busy=0, done=0, err=0, ss_act=0, ss_we=0, ss_addr=0, ss_wdat=0, out_dat=0, out_valid=0, in_ready=0.
- ss_act and busy rise the cycle after start and fall in the cycle done is high.
- Save, per byte: out_valid asserts SETTLE+1 cycles after the ss_addr change. With out_ready held high, the cycles per byte are SETTLE+2.
- Load:
  - in_ready is high only in WR_GET.
  - ss_we and ss_wdat change only on a clk edge and stay stable from WR_RISE entry until after the synchronized fall.
  - ss_addr changes only when ss_we=0.
- The M2 fall is seen 2–3 clk cycles after the real edge. The mapper has already latched by then, and the data is still held.

## Test plan
- Save with SS_LEN=4, SETTLE=2, mapper model returning ss_rdat=addr^8'hA5, out_ready always high → stream A5,A4,A7,A6; one done pulse; 4×4 cycles of busy plus FIN.
- Save with out_ready low for 10 cycles on byte 1 → out_valid and out_dat=A4 held for 10 cycles; no skipped or duplicated bytes.
- Load of 3 bytes 11,22,33 with m2 toggling at 1/12 clk → mapper model latches addr0=11, addr1=22, addr2=33, exactly one latch per address; ss_we is low on every address change.
- Load with m2 stuck low, M2_TMO=16 → err=1 and ss_we=0 within 17 cycles of entering WR_RISE; done pulses; the next start_save clears err.
- start_save and start_load in the same cycle → save runs and in_ready stays 0. A start_load pulse while busy has no effect.
- map_rst asserted at byte 2 of a load → next cycle ss_act=0, ss_we=0, busy=0, no done; a subsequent save runs normally from addr 0.
